// File: rtl/issue_ctrl_if.sv
// Decode-stage issue handshake between the ID pipeline register and the issue controller.
interface issue_ctrl_if;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        flush;
    logic        hold;
    logic        issue;
    logic        stall;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;

    modport master (
        output id_valid, id_instr, flush, hold,
        input  issue, stall, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_instr, flush, hold,
        output issue, stall, fwd_a, fwd_b
    );
endinterface

// File: rtl/issue_ctrl.sv
// RV32I decode-stage issue controller: tracks EX/MEM/WB destinations and decides issue/stall.
// Optional full bypass with load-use interlock when ISSUE_FWD_EN is defined.
module issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    issue_ctrl_if.slave ic
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } stage_t;

    stage_t ex_q, mem_q, wb_q;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, writes_rd, is_load;
    logic       hz1, hz2, live;

    assign opcode = ic.id_instr[6:0];
    assign rd     = ic.id_instr[11:7];
    assign rs1    = ic.id_instr[19:15];
    assign rs2    = ic.id_instr[24:20];

    always_comb begin
        use1      = 1'b0;
        use2      = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            OP_JALR, OP_IMM: begin
                use1      = 1'b1;
                writes_rd = 1'b1;
            end
            OP_LOAD: begin
                use1      = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OP_REG: begin
                use1      = 1'b1;
                use2      = 1'b1;
                writes_rd = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            default: ;
        endcase
        // x0 is never a real destination, so it never enters the shadow stages
        if (rd == 5'd0) writes_rd = 1'b0;
    end

    function automatic logic hit(input stage_t s, input logic [4:0] src);
        return s.v && (s.rd == src);
    endfunction

`ifdef ISSUE_FWD_EN
    function automatic logic [1:0] nearest(input stage_t e, input stage_t m,
                                           input stage_t w, input logic [4:0] src);
        if (hit(e, src))      return 2'b01;
        else if (hit(m, src)) return 2'b10;
        else if (hit(w, src)) return 2'b11;
        else                  return 2'b00;
    endfunction

    // only a load still in EX cannot be bypassed
    assign hz1 = use1 && (rs1 != 5'd0) && hit(ex_q, rs1) && ex_q.ld;
    assign hz2 = use2 && (rs2 != 5'd0) && hit(ex_q, rs2) && ex_q.ld;
`else
    // no write-through register file: any in-flight producer blocks the reader
    assign hz1 = use1 && (rs1 != 5'd0) && (hit(ex_q, rs1) || hit(mem_q, rs1) || hit(wb_q, rs1));
    assign hz2 = use2 && (rs2 != 5'd0) && (hit(ex_q, rs2) || hit(mem_q, rs2) || hit(wb_q, rs2));
`endif

    assign live     = ic.id_valid && !ic.flush && !rst;
    assign ic.issue = live && !ic.hold && !(hz1 || hz2);
    assign ic.stall = !rst && ((live && (hz1 || hz2)) || ic.hold);

`ifdef ISSUE_FWD_EN
    assign ic.fwd_a = (ic.issue && use1 && (rs1 != 5'd0)) ? nearest(ex_q, mem_q, wb_q, rs1) : 2'b00;
    assign ic.fwd_b = (ic.issue && use2 && (rs2 != 5'd0)) ? nearest(ex_q, mem_q, wb_q, rs2) : 2'b00;
`else
    assign ic.fwd_a = 2'b00;
    assign ic.fwd_b = 2'b00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!ic.hold) begin
            ex_q  <= ic.issue ? stage_t'{v: writes_rd, rd: rd, ld: is_load} : '0;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ic.id_instr[31:25], ic.id_instr[14:12], ex_q.ld, mem_q.ld, wb_q.ld};
endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed test-plan steps then random traffic against an age-based reference model.
module tb_issue_ctrl;
    logic clk;
    logic rst;
    issue_ctrl_if ic ();

    issue_ctrl dut (.clk(clk), .rst(rst), .ic(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // in-flight writers, age 1 = EX, 2 = MEM, 3 = WB
    typedef struct {
        int rd;
        bit ld;
        int age;
    } wr_t;
    wr_t inflight[$];

    logic       obs_issue, obs_stall;
    logic [1:0] obs_fa, obs_fb;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int r1, input int r2);
        logic [4:0] a, b, d;
        a = r1[4:0];
        b = r2[4:0];
        d = rd[4:0];
        return {7'b0, b, a, 3'b0, d, op};
    endfunction

    function automatic void dec(input logic [31:0] ins, output bit u1, output bit u2, output bit wr,
                                output int rd, output int s1, output int s2, output bit ld);
        rd = int'(ins[11:7]);
        s1 = int'(ins[19:15]);
        s2 = int'(ins[24:20]);
        u1 = 0; u2 = 0; wr = 0; ld = 0;
        case (ins[6:0])
            7'b0110111, 7'b0010111, 7'b1101111: wr = 1;
            7'b1100111, 7'b0010011:             begin u1 = 1; wr = 1; end
            7'b0000011:                         begin u1 = 1; wr = 1; ld = 1; end
            7'b0110011:                         begin u1 = 1; u2 = 1; wr = 1; end
            7'b0100011, 7'b1100011:             begin u1 = 1; u2 = 1; end
            default: ;
        endcase
        if (rd == 0) wr = 0;
    endfunction

    function automatic int youngest_age(input int src);
        int best = 0;
        foreach (inflight[i])
            if (inflight[i].rd == src && (best == 0 || inflight[i].age < best))
                best = inflight[i].age;
        return best;
    endfunction

    function automatic bit blocks(input bit used, input int src);
        int a;
        if (!used || src == 0) return 0;
        a = youngest_age(src);
        if (a == 0) return 0;
        if (!FWD) return 1;
        foreach (inflight[i])
            if (inflight[i].rd == src && inflight[i].age == 1 && inflight[i].ld) return 1;
        return 0;
    endfunction

    function automatic logic [1:0] sel_for(input bit used, input int src, input bit iss);
        int a;
        if (!FWD || !iss || !used || src == 0) return 2'b00;
        a = youngest_age(src);
        return (a == 0) ? 2'b00 : 2'(a);
    endfunction

    task automatic step(input bit v, input logic [31:0] ins, input bit fl, input bit hd, input bit rs);
        bit u1, u2, wr, ld, hz, e_issue, e_stall;
        int rd, s1, s2;
        logic [1:0] e_fa, e_fb;
        ic.id_valid = v;
        ic.id_instr = ins;
        ic.flush    = fl;
        ic.hold     = hd;
        rst         = rs;
        #4;
        dec(ins, u1, u2, wr, rd, s1, s2, ld);
        hz      = blocks(u1, s1) || blocks(u2, s2);
        e_issue = !rs && v && !fl && !hd && !hz;
        e_stall = !rs && ((v && !fl && hz) || hd);
        e_fa    = sel_for(u1, s1, e_issue);
        e_fb    = sel_for(u2, s2, e_issue);
        obs_issue = ic.issue;
        obs_stall = ic.stall;
        obs_fa    = ic.fwd_a;
        obs_fb    = ic.fwd_b;
        check("issue", {1'b0, obs_issue}, {1'b0, e_issue});
        check("stall", {1'b0, obs_stall}, {1'b0, e_stall});
        check("fwd_a", obs_fa, e_fa);
        check("fwd_b", obs_fb, e_fb);
        @(posedge clk);
        if (rs) begin
            inflight.delete();
        end else if (!hd) begin
            wr_t keep[$];
            foreach (inflight[i])
                if (inflight[i].age < 3) keep.push_back('{inflight[i].rd, inflight[i].ld, inflight[i].age + 1});
            inflight = keep;
            if (e_issue && wr) inflight.push_back('{rd, ld, 1});
        end
        #1;
    endtask

    // hold one instruction in ID until it issues; reports stall cycles and selects at issue
    task automatic present(input logic [31:0] ins, input string tag, output int stalls,
                           output logic [1:0] fa, output logic [1:0] fb);
        bit done = 0;
        stalls = 0;
        fa = 2'bxx;
        fb = 2'bxx;
        for (int k = 0; k < 8 && !done; k++) begin
            step(1, ins, 0, 0, 0);
            if (obs_issue) begin
                done = 1;
                fa = obs_fa;
                fb = obs_fb;
            end else begin
                stalls++;
            end
        end
        check({tag, "_issued"}, {1'b0, done}, 2'b01);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 32'h0, 0, 0, 0);
    endtask

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                           ST = 7'b0100011, IMM = 7'b0010011, OPR = 7'b0110011;

    initial begin
        int st;
        logic [1:0] fa, fb;
        logic [31:0] cur;
        logic [6:0] ops[13];
        ops = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, IMM, OPR, OPR, LD, 7'b1111111, 7'b0001011};

        ic.id_valid = 0; ic.id_instr = 0; ic.flush = 0; ic.hold = 0; rst = 1;
        @(posedge clk);
        #1;
        step(1, enc(OPR, 1, 2, 3), 0, 0, 1);
        check("rst_issue", {1'b0, obs_issue}, 2'b00);
        check("rst_stall", {1'b0, obs_stall}, 2'b00);
        idle(1);

        // RAW directly behind producer
        present(enc(OPR, 1, 2, 3), "prod", st, fa, fb);
        present(enc(OPR, 4, 1, 5), "raw", st, fa, fb);
        check("raw_stalls", 2'(st), FWD ? 2'd0 : 2'd3);
        check("raw_fwd_a", fa, FWD ? 2'b01 : 2'b00);
        check("raw_fwd_b", fb, 2'b00);
        idle(3);

        // load-use
        present(enc(LD, 6, 1, 0), "lw", st, fa, fb);
        present(enc(OPR, 7, 6, 6), "lu", st, fa, fb);
        check("lu_stalls", 2'(st), FWD ? 2'd1 : 2'd3);
        check("lu_fwd_a", fa, FWD ? 2'b10 : 2'b00);
        check("lu_fwd_b", fb, FWD ? 2'b10 : 2'b00);
        idle(3);

        // x0 never hazards
        present(enc(IMM, 0, 0, 1), "x0w", st, fa, fb);
        present(enc(OPR, 8, 0, 0), "x0r", st, fa, fb);
        check("x0_stalls", 2'(st), 2'd0);
        check("x0_fwd_a", fa, 2'b00);
        idle(3);

        // flush during a load-use stall
        present(enc(LD, 9, 0, 0), "lw9", st, fa, fb);
        step(1, enc(OPR, 10, 9, 9), 0, 0, 0);
        check("fl_pre_stall", {1'b0, obs_stall}, 2'b01);
        step(1, enc(OPR, 10, 9, 9), 1, 0, 0);
        check("fl_issue", {1'b0, obs_issue}, 2'b00);
        check("fl_stall", {1'b0, obs_stall}, 2'b00);
        idle(3);

        // hold with producer in MEM
        present(enc(OPR, 11, 1, 2), "p11", st, fa, fb);
        idle(1);
        step(1, enc(OPR, 12, 11, 0), 0, 1, 0);
        check("hold_stall", {1'b0, obs_stall}, 2'b01);
        step(1, enc(OPR, 12, 11, 0), 0, 1, 0);
        check("hold_issue", {1'b0, obs_issue}, 2'b00);
        present(enc(OPR, 12, 11, 0), "c12", st, fa, fb);
        check("hold_stalls", 2'(st), FWD ? 2'd0 : 2'd2);
        check("hold_fwd_a", fa, FWD ? 2'b10 : 2'b00);
        idle(3);

        // reset mid-stall
        present(enc(LD, 13, 0, 0), "lw13", st, fa, fb);
        step(1, enc(OPR, 14, 13, 13), 0, 0, 0);
        check("rs_pre_stall", {1'b0, obs_stall}, 2'b01);
        step(1, enc(OPR, 14, 13, 13), 0, 0, 1);
        check("rs_stall", {1'b0, obs_stall}, 2'b00);
        step(1, enc(OPR, 14, 13, 13), 0, 0, 0);
        check("rs_post_issue", {1'b0, obs_issue}, 2'b01);
        check("rs_post_fwd", obs_fa, 2'b00);

        // random traffic on a small register set to provoke hazards
        cur = enc(OPR, 1, 2, 3);
        for (int n = 0; n < 600; n++) begin
            bit v, fl, hd, rs;
            v  = ($urandom_range(0, 9) != 0);
            fl = ($urandom_range(0, 9) == 0);
            hd = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 49) == 0);
            step(v, cur, fl, hd, rs);
            if (obs_issue || fl || !v || rs) begin
                cur = enc(ops[$urandom_range(0, 12)], $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
                cur[31:25] = 7'($urandom);
                cur[14:12] = 3'($urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
